soc_pio_in_edge: RTL

- Parametrised Avalon-MM input PIO for HPS/FPGA switch, button and status-line sampling.
- Synchronises a DATA_WIDTH-bit asynchronous input bus and optionally debounces it.
- Detects per-bit rising and/or falling edges, each individually enabled, and latches them in a write-1-to-clear capture register.
- Raises a level interrupt on any masked captured edge; sits on the lightweight HPS-to-FPGA bridge as a 32-bit slave.

---
 rtl/soc_pio_pkg.sv | 24 ++
 rtl/soc_pio_debounce_bit.sv | 63 ++++++
 rtl/soc_pio_in_edge.sv | 110 +++++++++++
 3 files changed

// File: rtl/soc_pio_pkg.sv
// Shared register map and PARAMS layout for the input PIO.
// Debounce presence is selected with the SOC_PIO_IN_DEBOUNCE_EN macro.
package soc_pio_pkg;

   typedef logic [2:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA     = 3'd0;
   localparam pio_addr_t ADDR_RISE_EN  = 3'd1;
   localparam pio_addr_t ADDR_IRQ_MASK = 3'd2;
   localparam pio_addr_t ADDR_EDGE_CAP = 3'd3;
   localparam pio_addr_t ADDR_FALL_EN  = 3'd4;
   localparam pio_addr_t ADDR_PARAMS   = 3'd5;

   localparam int PARAMS_WIDTH_LSB    = 0;
   localparam int PARAMS_WIDTH_MSB    = 5;
   localparam int PARAMS_DEBOUNCE_BIT = 8;

`ifdef SOC_PIO_IN_DEBOUNCE_EN
   localparam bit DEBOUNCE_PRESENT = 1'b1;
`else
   localparam bit DEBOUNCE_PRESENT = 1'b0;
`endif

endpackage

// File: rtl/soc_pio_debounce_bit.sv
// One input line: SYNC_STAGES-flop synchroniser, optional debounce counter
// (SOC_PIO_IN_DEBOUNCE_EN), then a registered filtered output.
module soc_pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DEBOUNCE_CNT_W  = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   output logic filt_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic                   filt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_IN_DEBOUNCE_EN
   localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                      deb_q, deb_d;
   logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;

   // Any sample agreeing with the debounced level restarts the stability count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync != deb_q) begin
         if (cnt_q == CNT_LAST) deb_d = sync;
         else                   cnt_d = cnt_q + DEBOUNCE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q  <= 1'b0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
         filt_q <= deb_q;
      end
   end
`else
   localparam int unused_deb_cfg = DEBOUNCE_CYCLES + DEBOUNCE_CNT_W;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) filt_q <= 1'b0;
      else          filt_q <= sync;
   end
`endif

   assign filt_o = filt_q;

endmodule

// File: rtl/soc_pio_in_edge.sv
// Avalon-MM input PIO: synchronised/filtered inputs, per-bit rise/fall capture
// (W1C) and masked level irq. Debounce is compiled in with SOC_PIO_IN_DEBOUNCE_EN.
module soc_pio_in_edge
   import soc_pio_pkg::*;
#(
   parameter int DATA_WIDTH      = 14,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DEBOUNCE_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  pio_addr_t             address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] filt, filt_d_q;
   logic [DATA_WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
   logic [DATA_WIDTH-1:0] rise_ev, fall_ev, cap_clr, wdata;
   logic [31:0]           readdata_q, readdata_d, params_word;
   logic                  wr_en;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      soc_pio_debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .DEBOUNCE_CNT_W (DEBOUNCE_CNT_W)
      ) u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .in_i   (in_port[i]),
         .filt_o (filt[i])
      );
   end

   if (DATA_WIDTH < 32) begin : g_wdata_unused
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:DATA_WIDTH];
   end

   assign wr_en   = chipselect & ~write_n;
   assign wdata   = writedata[DATA_WIDTH-1:0];
   assign rise_ev = filt & ~filt_d_q & rise_en_q;
   assign fall_ev = ~filt & filt_d_q & fall_en_q;

   // A fresh edge overrides a same-cycle W1C on the same bit.
   always_comb begin
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      irq_mask_d = irq_mask_q;
      cap_clr    = '0;
      if (wr_en) begin
         case (address)
            ADDR_RISE_EN:  rise_en_d  = wdata;
            ADDR_IRQ_MASK: irq_mask_d = wdata;
            ADDR_EDGE_CAP: cap_clr    = wdata;
            ADDR_FALL_EN:  fall_en_d  = wdata;
            default: ;
         endcase
      end
      edge_cap_d = (edge_cap_q & ~cap_clr) | rise_ev | fall_ev;
   end

   always_comb begin
      params_word = '0;
      params_word[PARAMS_WIDTH_MSB:PARAMS_WIDTH_LSB] = 6'(DATA_WIDTH);
      params_word[PARAMS_DEBOUNCE_BIT]               = DEBOUNCE_PRESENT;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:     readdata_d = 32'(filt);
         ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
         ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
         ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
         ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
         ADDR_PARAMS:   readdata_d = params_word;
         default:       readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_d_q   <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         readdata_q <= '0;
      end else begin
         filt_d_q   <= filt;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
